// File: rtl/leg_solver_seq.sv
// Missing-leg solver: y = floor(sqrt(r*r - x*x)) computed over 2W+1 cycles
// with a start/done handshake (shift-add squaring, then restoring square root).
module leg_solver_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] r_in,
    input  logic [W-1:0] x_in,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] y_out,
    output logic         err
);

    localparam int unsigned W2 = 2 * W;
    localparam int unsigned RW = W + 2;
    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [2:0] {IDLE, SQUARE, SUB, ROOT, DONE} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [W-1:0]   mr_q, mx_q;
    logic [W2-1:0]  ar_q, ax_q;
    logic [W2-1:0]  sr_q, sx_q;
    logic [W2-1:0]  d_q;
    logic [RW-1:0]  rem_q;
    logic [W-1:0]   root_q;

    logic           last_c;
    logic [RW-1:0]  rem_sh_c;
    logic [RW:0]    trial_c;
    logic           keep_c;
    logic [RW-1:0]  rem_nx_c;
    logic [W-1:0]   root_nx_c;

    assign last_c = (cnt_q == CW'(W - 1));

    // One restoring root step: bring down two radicand bits, try subtracting {root,01}.
    always_comb begin
        rem_sh_c  = RW'({rem_q, d_q[W2-1 -: 2]});
        trial_c   = {1'b0, rem_sh_c} - {1'b0, root_q, 2'b01};
        keep_c    = ~trial_c[RW];
        rem_nx_c  = keep_c ? trial_c[RW-1:0] : rem_sh_c;
        root_nx_c = {root_q[W-2:0], keep_c};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SQUARE;
            SQUARE:  if (last_c) state_d = SUB;
            SUB:     state_d = (sx_q > sr_q) ? DONE : ROOT;
            ROOT:    if (last_c) state_d = DONE;
            DONE:    state_d = start ? SQUARE : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_d == SQUARE) || (state_d == SUB) || (state_d == ROOT);
            done <= (state_d == DONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mr_q   <= '0;
            mx_q   <= '0;
            ar_q   <= '0;
            ax_q   <= '0;
            sr_q   <= '0;
            sx_q   <= '0;
            d_q    <= '0;
            rem_q  <= '0;
            root_q <= '0;
            y_out  <= '0;
            err    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        mr_q  <= r_in;
                        mx_q  <= x_in;
                        ar_q  <= W2'(r_in);
                        ax_q  <= W2'(x_in);
                        sr_q  <= '0;
                        sx_q  <= '0;
                        cnt_q <= '0;
                        y_out <= '0;
                        err   <= 1'b0;
                    end
                end
                SQUARE: begin
                    sr_q  <= sr_q + (mr_q[0] ? ar_q : '0);
                    sx_q  <= sx_q + (mx_q[0] ? ax_q : '0);
                    ar_q  <= ar_q << 1;
                    ax_q  <= ax_q << 1;
                    mr_q  <= mr_q >> 1;
                    mx_q  <= mx_q >> 1;
                    cnt_q <= last_c ? '0 : cnt_q + CW'(1);
                end
                SUB: begin
                    if (sx_q > sr_q) begin
                        y_out <= '0;
                        err   <= 1'b1;
                    end else begin
                        d_q    <= sr_q - sx_q;
                        rem_q  <= '0;
                        root_q <= '0;
                        cnt_q  <= '0;
                    end
                end
                ROOT: begin
                    d_q    <= d_q << 2;
                    rem_q  <= rem_nx_c;
                    root_q <= root_nx_c;
                    cnt_q  <= last_c ? '0 : cnt_q + CW'(1);
                    if (last_c) y_out <= root_nx_c;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_leg_solver_seq.sv
// Self-checking bench for leg_solver_seq: directed vector table, handshake corner
// sequences and randomized operands against an arithmetic reference model.
module tb_leg_solver_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] r_in, x_in;
    logic         busy, done, err;
    logic [W-1:0] y_out;

    int n_pass = 0;
    int n_total = 0;

    leg_solver_seq #(.W(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .r_in(r_in), .x_in(x_in),
        .busy(busy), .done(done), .y_out(y_out), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int r;
        int x;
        int y;
        int e;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference: largest y whose square does not exceed r^2 - x^2.
    function automatic int ref_y(input int r, input int x);
        int d;
        int y;
        if (x > r) return 0;
        d = r * r - x * x;
        y = 0;
        while ((y + 1) * (y + 1) <= d) y++;
        return y;
    endfunction

    // Issue one op from the current negedge; optionally poke start mid-flight.
    // Returns at the negedge where done is first seen.
    task automatic run_op(input int r, input int x, input int poke,
                          output int lat, output int busy_cnt, output int yv, output int ev);
        int edges;
        r_in  = W'(r);
        x_in  = W'(x);
        start = 1'b1;
        @(posedge clk);
        edges = 1;
        busy_cnt = 0;
        lat = -1;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = edges;
                break;
            end
            if (busy) busy_cnt++;
            if (edges > 40) begin
                chk("done_timeout", edges, 2 * W + 2);
                break;
            end
            if (edges == poke) begin
                start = 1'b1;
                r_in  = W'($urandom);
                x_in  = W'($urandom);
            end
            @(posedge clk);
            edges++;
        end
        yv = int'(y_out);
        ev = int'(err);
    endtask

    vec_t vecs[12];

    initial begin
        int lat, bc, yv, ev, r, x, pulses;

        rst_n = 1'b0;
        start = 1'b0;
        r_in  = '0;
        x_in  = '0;
        #12;
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_y", int'(y_out), 0);
        chk("rst_err", int'(err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        vecs[0]  = '{5, 3, 4, 0};
        vecs[1]  = '{10, 7, 7, 0};
        vecs[2]  = '{255, 0, 255, 0};
        vecs[3]  = '{0, 0, 0, 0};
        vecs[4]  = '{3, 5, 0, 1};
        vecs[5]  = '{13, 5, 12, 0};
        vecs[6]  = '{200, 200, 0, 0};
        vecs[7]  = '{255, 255, 0, 0};
        vecs[8]  = '{0, 1, 0, 1};
        vecs[9]  = '{255, 254, 22, 0};
        vecs[10] = '{1, 0, 1, 0};
        vecs[11] = '{128, 100, 79, 0};

        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].r, vecs[i].x, 0, lat, bc, yv, ev);
            chk($sformatf("vec%0d_y", i), yv, vecs[i].y);
            chk($sformatf("vec%0d_err", i), ev, vecs[i].e);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].e ? W + 2 : 2 * W + 2);
            chk($sformatf("vec%0d_busy", i), bc, vecs[i].e ? W + 1 : 2 * W + 1);
            @(negedge clk);
            chk($sformatf("vec%0d_pulse", i), int'(done), 0);
            chk($sformatf("vec%0d_hold", i), int'(y_out), vecs[i].y);
        end

        // start poked mid-ROOT with fresh operands must not disturb the result
        run_op(5, 3, 12, lat, bc, yv, ev);
        chk("poke_y", yv, 4);
        chk("poke_lat", lat, 2 * W + 2);

        // start held in DONE: back-to-back acceptance
        run_op(13, 5, 0, lat, bc, yv, ev);
        run_op(10, 7, 0, lat, bc, yv, ev);
        chk("b2b_y", yv, 7);
        chk("b2b_lat", lat, 2 * W + 2);
        @(negedge clk);

        // asynchronous reset mid-SQUARE aborts without a done pulse
        r_in  = 8'd200;
        x_in  = 8'd3;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", int'(busy), 0);
        chk("arst_done", int'(done), 0);
        chk("arst_y", int'(y_out), 0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("arst_no_done", pulses, 0);
        run_op(255, 0, 0, lat, bc, yv, ev);
        chk("arst_fresh_y", yv, 255);
        chk("arst_fresh_lat", lat, 2 * W + 2);

        // randomized operands against the reference model
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 255));
            x = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, r)) : int'($urandom_range(0, 255));
            run_op(r, x, 0, lat, bc, yv, ev);
            chk($sformatf("rnd_y r=%0d x=%0d", r, x), yv, ref_y(r, x));
            chk($sformatf("rnd_err r=%0d x=%0d", r, x), ev, (x > r) ? 1 : 0);
            chk($sformatf("rnd_lat r=%0d x=%0d", r, x), lat, (x > r) ? W + 2 : 2 * W + 2);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
